// File: rtl/csync_dejitter_gen.sv
// Composite-sync dejitter: stretches short lines to nominal length by gating CLK_i; CSYNC_o lags CSYNC_i by 1 cycle (+gap on short lines).
// No backpressure: free-running, every CLK_i cycle is consumed.
module csync_dejitter_gen #(
  parameter int H_CNT_W    = 11,
  parameter int H_LONG     = 1364,
  parameter int H_SHORT    = 1360,
  parameter int H_MIN      = 1024,
  parameter int LOCK_LINES = 8
) (
  input  logic               CLK_i,
  input  logic               RST_i,
  input  logic               CSYNC_i,
  input  logic               BYPASS_i,
  output logic               GCLK_o,
  output logic               GCLK_EN_o,
  output logic               CSYNC_o,
  output logic               LOCKED_o,
  output logic               SHORT_LINE_o,
  output logic [H_CNT_W-1:0] H_CNT_o
);

  localparam logic [H_CNT_W-1:0] H_MIN_C    = H_CNT_W'(H_MIN);
  localparam logic [H_CNT_W-1:0] SHORT_LAST = H_CNT_W'(H_SHORT - 1);
  localparam logic [H_CNT_W-1:0] LONG_LAST  = H_CNT_W'(H_LONG - 1);
  localparam logic [3:0]         G_CYC      = 4'(H_LONG - H_SHORT);
  localparam logic [7:0]         LOCK_MAX   = 8'(LOCK_LINES);

  logic [H_CNT_W-1:0] h_cnt;
  logic               csync_prev;
  logic [3:0]         g_cyc;
  logic [7:0]         lock_cnt;
  logic               gclk_en;

  logic h_sat;
  logic qual_edge;
  logic line_short;
  logic line_valid;
  logic compensate;

  // h_cnt holds L-1 at the edge that ends a line of length L
  assign h_sat      = &h_cnt;
  assign qual_edge  = csync_prev & ~CSYNC_i & (h_cnt >= H_MIN_C);
  assign line_short = (h_cnt == SHORT_LAST);
  assign line_valid = line_short | (h_cnt == LONG_LAST);
  assign compensate = qual_edge & line_short & LOCKED_o & ~BYPASS_i;

  always_ff @(posedge CLK_i or posedge RST_i) begin
    if (RST_i) begin
      h_cnt        <= '0;
      csync_prev   <= 1'b1;
      g_cyc        <= '0;
      lock_cnt     <= '0;
      CSYNC_o      <= 1'b1;
      LOCKED_o     <= 1'b0;
      SHORT_LINE_o <= 1'b0;
    end else begin
      csync_prev   <= CSYNC_i;
      SHORT_LINE_o <= compensate;
      LOCKED_o     <= (lock_cnt == LOCK_MAX);

      if (qual_edge)
        h_cnt <= '0;
      else if (!h_sat)
        h_cnt <= h_cnt + 1'b1;

      if (BYPASS_i)
        g_cyc <= '0;
      else if (compensate)
        g_cyc <= G_CYC;
      else if (g_cyc != 4'd0)
        g_cyc <= g_cyc - 4'd1;

      // Sync output freezes across the gap so its fall lands G_CYC cycles late
      if (!compensate && (qual_edge || g_cyc <= 4'd1))
        CSYNC_o <= CSYNC_i;

      if (qual_edge) begin
        if (!line_valid)
          lock_cnt <= '0;
        else if (lock_cnt != LOCK_MAX)
          lock_cnt <= lock_cnt + 8'd1;
      end else if (h_sat) begin
        lock_cnt <= '0;
      end
    end
  end

  // Enable changes only while CLK_i is low, so GCLK_o never sees a runt pulse
  always_ff @(negedge CLK_i or posedge RST_i) begin
    if (RST_i)
      gclk_en <= 1'b1;
    else
      gclk_en <= (g_cyc == 4'd0) | BYPASS_i;
  end

  assign GCLK_EN_o = gclk_en;
  assign GCLK_o    = CLK_i & gclk_en;
  assign H_CNT_o   = h_cnt;

endmodule

// File: tb/tb_csync_dejitter_gen.sv
// Directed bench for csync_dejitter_gen: per-line expectations queued at drive time, compared after the line.
module tb_csync_dejitter_gen;
  localparam int W      = 11;
  localparam int SYNC_W = 100;

  logic         CLK_i = 1'b0;
  logic         RST_i;
  logic         CSYNC_i;
  logic         BYPASS_i;
  logic         GCLK_o;
  logic         GCLK_EN_o;
  logic         CSYNC_o;
  logic         LOCKED_o;
  logic         SHORT_LINE_o;
  logic [W-1:0] H_CNT_o;

  csync_dejitter_gen dut (
    .CLK_i        (CLK_i),
    .RST_i        (RST_i),
    .CSYNC_i      (CSYNC_i),
    .BYPASS_i     (BYPASS_i),
    .GCLK_o       (GCLK_o),
    .GCLK_EN_o    (GCLK_EN_o),
    .CSYNC_o      (CSYNC_o),
    .LOCKED_o     (LOCKED_o),
    .SHORT_LINE_o (SHORT_LINE_o),
    .H_CNT_o      (H_CNT_o)
  );

  always #5 CLK_i = ~CLK_i;

  int clk_n  = 0;
  int gclk_n = 0;
  always @(posedge CLK_i) clk_n++;
  always @(posedge GCLK_o) gclk_n++;

  int n_asserts = 0;
  int n_fail    = 0;
  int line_no   = 0;

  typedef struct {
    int supp;
    int shorts;
    int dly;
    int lk1;
    int lkend;
    int hcnt;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK_i);
    #1;
  endtask

  // CSYNC_i high for n cycles, optionally with an early pulse that must be ignored
  task automatic idle(input int n, input bit pulse, input int exp_h);
    for (int i = 0; i < n; i++) begin
      CSYNC_i = !(pulse && i >= 500 && i < 530);
      tick();
    end
    check($sformatf("idle%0d_hcnt", line_no), H_CNT_o, exp_h);
  endtask

  // One line of len cycles; its leading edge judges the previous line
  task automatic run_line(input int len, input bit serr, input int supp, input int shorts,
                          input int dly, input int lk1, input int lkend);
    exp_t e;
    int   c0, g0, sh, first, l1;
    sb.push_back('{supp, shorts, dly, lk1, lkend, len - 1});
    line_no++;
    c0 = clk_n;
    g0 = gclk_n;
    sh = 0;
    first = -1;
    l1 = -1;
    for (int i = 0; i < len; i++) begin
      CSYNC_i = !((i < SYNC_W) || (serr && ((i >= 600 && i < 630) || (i >= 900 && i < 930))));
      tick();
      if (SHORT_LINE_o === 1'b1) sh++;
      if (first < 0 && CSYNC_o === 1'b0) first = i + 1;
      if (i == 1) l1 = int'(LOCKED_o);
    end
    e = sb.pop_front();
    check($sformatf("line%0d_suppressed", line_no), (clk_n - c0) - (gclk_n - g0), e.supp);
    check($sformatf("line%0d_short_pulses", line_no), sh, e.shorts);
    check($sformatf("line%0d_csync_delay", line_no), first, e.dly);
    check($sformatf("line%0d_locked_early", line_no), l1, e.lk1);
    check($sformatf("line%0d_locked_end", line_no), LOCKED_o, e.lkend);
    check($sformatf("line%0d_hcnt_end", line_no), H_CNT_o, e.hcnt);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_i    = 1'b1;
    CSYNC_i  = 1'b1;
    BYPASS_i = 1'b0;
    #12;
    check("rst_hcnt", H_CNT_o, 0);
    check("rst_csync", CSYNC_o, 1);
    check("rst_gclk_en", GCLK_EN_o, 1);
    check("rst_locked", LOCKED_o, 0);
    check("rst_short", SHORT_LINE_o, 0);
    @(negedge CLK_i);
    #1 RST_i = 1'b0;

    // Early pulse below H_MIN must not restart the counter
    idle(1100, 1'b1, 1100);

    // Alternating long/short lines until lock
    for (int k = 0; k < 8; k++)
      run_line((k % 2 == 0) ? 1364 : 1360, 1'b0, 0, 0, 1, 0, 0);
    run_line(1364, 1'b0, 0, 0, 1, 1, 1);
    run_line(1360, 1'b0, 0, 0, 1, 1, 1);
    run_line(1364, 1'b0, 4, 1, 5, 1, 1);
    run_line(1360, 1'b0, 0, 0, 1, 1, 1);
    run_line(1200, 1'b0, 4, 1, 5, 1, 1);
    // Bad 1200 line drops lock; the following short line is not gated
    run_line(1360, 1'b0, 0, 0, 1, 0, 0);
    for (int k = 0; k < 7; k++)
      run_line((k % 2 == 0) ? 1360 : 1364, (k < 2), 0, 0, 1, 0, 0);
    run_line(1364, 1'b0, 0, 0, 1, 1, 1);

    // Sync loss: counter saturates and lock clears
    idle(2100, 1'b0, 2047);
    check("sat_locked", LOCKED_o, 0);

    for (int k = 0; k < 8; k++)
      run_line((k % 2 == 0) ? 1364 : 1360, 1'b0, 0, 0, 1, 0, 0);
    run_line(1360, 1'b0, 0, 0, 1, 1, 1);
    BYPASS_i = 1'b1;
    run_line(1360, 1'b0, 0, 0, 1, 1, 1);
    BYPASS_i = 1'b0;

    // Compensated line, reset asserted in the second gated cycle while CLK_i is low
    CSYNC_i = 1'b0;
    tick();
    check("gate_short_pulse", SHORT_LINE_o, 1);
    tick();
    tick();
    @(negedge CLK_i);
    #1;
    check("gate_en_low", GCLK_EN_o, 0);
    RST_i = 1'b1;
    #1;
    check("midrst_gclk_en", GCLK_EN_o, 1);
    check("midrst_gclk", GCLK_o, 0);
    check("midrst_csync", CSYNC_o, 1);
    check("midrst_locked", LOCKED_o, 0);
    check("midrst_short", SHORT_LINE_o, 0);
    check("midrst_hcnt", H_CNT_o, 0);
    #1;
    RST_i   = 1'b0;
    CSYNC_i = 1'b1;

    idle(1100, 1'b0, 1100);
    for (int k = 0; k < 8; k++)
      run_line((k % 2 == 0) ? 1364 : 1360, 1'b0, 0, 0, 1, 0, 0);
    run_line(1364, 1'b0, 0, 0, 1, 1, 1);

    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/csync_dejitter_gen.md
CSYNC_DEJITTER_GEN -- requirements
Module: csync_dejitter_gen

Interface
REQ-001 Parameter H_CNT_W, default 11: width of the line counter.
REQ-002 Parameter H_LONG, default 1364: nominal long-line length in clock cycles.
REQ-003 Parameter H_SHORT, default 1360: short-line length; H_LONG-H_SHORT SHALL be 1..15.
REQ-004 Parameter H_MIN, default 1024: minimum count before a sync edge is accepted.
REQ-005 Parameter LOCK_LINES, default 8: consecutive valid lines required for lock, 1..255.
REQ-006 Port CLK_i input 1: master clock; all state in this clock domain.
REQ-007 Port RST_i input 1: reset, asynchronous, active-high.
REQ-008 Port CSYNC_i input 1: composite sync, active-low, already synchronous to CLK_i.
REQ-009 Port BYPASS_i input 1: 1 = never gate, CSYNC_o follows CSYNC_i with 1-cycle delay.
REQ-010 Port GCLK_o output 1: gated clock, CLK_i AND GCLK_EN_o.
REQ-011 Port GCLK_EN_o output 1: clock-gate enable.
REQ-012 Port CSYNC_o output 1: dejittered composite sync.
REQ-013 Port LOCKED_o output 1: line-length lock indicator.
REQ-014 Port SHORT_LINE_o output 1: one-cycle pulse per compensated short line.
REQ-015 Port H_CNT_o output H_CNT_W: current line counter value.

Function
REQ-016 Qualified edge SHALL mean: CSYNC_prev==1, CSYNC_i==0 and h_cnt>=H_MIN; line length L = h_cnt+1.
REQ-017 On a qualified edge, h_cnt SHALL load 0; otherwise h_cnt SHALL increment, saturating at all-ones.
REQ-018 On a qualified edge with L==H_SHORT, LOCKED_o==1 and BYPASS_i==0: g_cyc SHALL load H_LONG-H_SHORT, CSYNC_o SHALL hold, and SHORT_LINE_o SHALL pulse 1 the following cycle.
REQ-019 On any other qualified edge, CSYNC_o SHALL load CSYNC_i.
REQ-020 On non-qualified cycles: g_cyc decrements when >0; CSYNC_o loads CSYNC_i only when g_cyc<=1.
REQ-021 GCLK_EN_o SHALL update on the falling edge of CLK_i to (g_cyc==0) OR BYPASS_i, so that GCLK_o is glitch-free.
REQ-022 While gating, exactly H_LONG-H_SHORT rising edges of CLK_i SHALL be suppressed on GCLK_o per short line.
REQ-023 BYPASS_i rising mid-gate: g_cyc SHALL clear on the next rising edge; GCLK_EN_o SHALL go 1 at the next falling edge.
REQ-024 lock_cnt on a qualified edge: increments, saturating at LOCK_LINES, if L==H_SHORT or L==H_LONG; otherwise clears to 0.
REQ-025 lock_cnt SHALL clear when h_cnt reaches all-ones (sync loss).
REQ-026 LOCKED_o SHALL be registered: 1 iff lock_cnt==LOCK_LINES, one cycle after the count reaches that value.
REQ-027 Falling CSYNC_i edges with h_cnt<H_MIN (equalisation and serration pulses) SHALL NOT reset h_cnt or affect lock_cnt.
REQ-028 H_CNT_o SHALL equal the h_cnt register.

Reset
REQ-029 RST_i high SHALL asynchronously set h_cnt=0, g_cyc=0, lock_cnt=0, CSYNC_prev=1, CSYNC_o=1, GCLK_EN_o=1, LOCKED_o=0, SHORT_LINE_o=0.
REQ-030 Reset asserted mid-gate SHALL restore GCLK_EN_o=1 immediately, with no truncated GCLK_o high pulse.
REQ-031 After release, the first qualified edge SHALL be counted only once h_cnt>=H_MIN.

Verification
REQ-032 Nine lines alternating 1364/1360 -> LOCKED_o=1 after the 8th valid line; each subsequent 1360 line -> 4 missing GCLK_o pulses, SHORT_LINE_o=1 for one cycle, CSYNC_o fall delayed 4 cycles.
REQ-033 Locked stream, then one 1200-cycle line -> LOCKED_o=0 one cycle later, no gating on the following 1360 line.
REQ-034 Serration pulses at h_cnt=600 and 900 -> h_cnt not reset, lock_cnt unchanged.
REQ-035 CSYNC_i held high for 2048+ cycles -> h_cnt saturates at 2047, lock_cnt=0, LOCKED_o=0.
REQ-036 BYPASS_i=1 with a locked 1360 line -> GCLK_o continuous, SHORT_LINE_o=0, CSYNC_o = CSYNC_i delayed 1 cycle.
REQ-037 RST_i pulsed during the 2nd gated cycle -> GCLK_EN_o=1 immediately, all outputs at reset values, relock after 8 valid lines.
